// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: FSM state encoding and default width.
package pwm_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a slow level that is synchronous to clk.
// The output is high for one clk per low-to-high transition of din.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic tick
);

  logic din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din;
  end

  assign tick = din & ~din_q;

endmodule

// File: rtl/pwm_gen.sv
// PWM generator clocked by div_clk rising edges, with shadowed period/duty.
// Optional single-period mode is enabled by defining PWM_GEN_ONESHOT_EN.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             en,
`ifdef PWM_GEN_ONESHOT_EN
  input  logic             oneshot,
`endif
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] period_reg, duty_reg;
  logic [WIDTH-1:0] pend_period_reg, pend_duty_reg;
  logic             pend_reg;
  logic             pwm_reg, pwm_next;

  logic             tick;
  logic             accept;
  logic             last;
  logic             wrap;
  logic             apply;
  logic             start;
  logic             start_ok;
  logic             single_period;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] eff_duty;

  edge_det u_edge_det (
    .clk  (clk),
    .rst  (rst),
    .din  (div_clk),
    .tick (tick)
  );

  assign accept   = cfg_valid & ~pend_reg;
  assign last     = (cnt_reg == (period_reg - ONE));
  assign wrap     = tick & last & (state_reg != IDLE);
  assign cnt_inc  = last ? '0 : cnt_reg + ONE;
  // A pending config lands either immediately when idle or at a period boundary.
  assign apply    = pend_reg & ((state_reg == IDLE) | wrap);
  assign eff_duty = apply ? pend_duty_reg : duty_reg;
  // Holding off the start for one clk when a config arrives alongside en lets it apply first.
  assign start    = (state_reg == IDLE) & en & ~accept & start_ok;

`ifdef PWM_GEN_ONESHOT_EN
  logic oneshot_reg;
  logic armed_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oneshot_reg <= 1'b0;
      armed_reg   <= 1'b1;
    end else begin
      if (start) oneshot_reg <= oneshot;
      if (!en)                  armed_reg <= 1'b1;
      else if (start & oneshot) armed_reg <= 1'b0;
    end
  end

  assign start_ok      = armed_reg;
  assign single_period = oneshot_reg;
`else
  assign start_ok      = 1'b1;
  assign single_period = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN, STOP: begin
        if (wrap && (!en || single_period)) state_next = IDLE;
        else                                state_next = en ? RUN : STOP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next = cnt_reg;
    pwm_next = pwm_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        pwm_next = start ? (eff_duty != '0) : 1'b0;
      end
      RUN, STOP: begin
        if (tick) begin
          if (state_next == IDLE) begin
            cnt_next = '0;
            pwm_next = 1'b0;
          end else begin
            cnt_next = cnt_inc;
            pwm_next = (cnt_inc < eff_duty);
          end
        end
      end
      default: begin
        cnt_next = '0;
        pwm_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg         <= '0;
      pwm_reg         <= 1'b0;
      period_reg      <= ONE;
      duty_reg        <= '0;
      pend_reg        <= 1'b0;
      pend_period_reg <= ONE;
      pend_duty_reg   <= '0;
    end else begin
      cnt_reg <= cnt_next;
      pwm_reg <= pwm_next;
      if (apply) begin
        period_reg <= pend_period_reg;
        duty_reg   <= pend_duty_reg;
        pend_reg   <= 1'b0;
      end else if (accept) begin
        pend_period_reg <= (cfg_period == '0) ? ONE : cfg_period;
        pend_duty_reg   <= cfg_duty;
        pend_reg        <= 1'b1;
      end
    end
  end

  assign cfg_ready   = ~pend_reg;
  assign pwm_out     = pwm_reg;
  assign period_done = wrap;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: each div_clk tick pushes its expected outcome to a
// scoreboard that is popped when the DUT responds.
module tb_pwm_gen;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         div_clk = 1'b0;
  logic         en = 1'b0;
  logic         oneshot = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cfg_duty = '0;
  logic         pwm_out;
  logic         period_done;
  logic         busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic  pwm;
    logic  done;
    string tag;
  } exp_t;
  exp_t sb[$];

  int m_per, m_duty, m_cnt, m_pp, m_pd;
  bit m_pend;

  always #5 clk = ~clk;

  pwm_gen #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_clk     (div_clk),
    .en          (en),
`ifdef PWM_GEN_ONESHOT_EN
    .oneshot     (oneshot),
`endif
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One div_clk period of 4 clks: high for two, low for two.
  task automatic tick_expect(input logic exp_pwm, input logic exp_done, input string tag);
    exp_t e;
    e.pwm = exp_pwm; e.done = exp_done; e.tag = tag;
    sb.push_back(e);
    div_clk = 1'b1;
    #2;
    chk({sb[0].tag, "_done"}, period_done, sb[0].done);
    cyc();
    e = sb.pop_front();
    chk({e.tag, "_pwm"}, pwm_out, e.pwm);
    chk({e.tag, "_hold"}, period_done, 1'b0);
    cyc();
    div_clk = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic model_tick(input string tag);
    bit lst;
    lst = (m_cnt == m_per - 1);
    if (lst) begin
      m_cnt = 0;
      if (m_pend) begin
        m_per = m_pp; m_duty = m_pd; m_pend = 0;
      end
    end else begin
      m_cnt++;
    end
    tick_expect(m_cnt < m_duty, lst, tag);
  endtask

  task automatic send_cfg(input int per, input int duty, input bit idle);
    chk("cfg_ready_before", cfg_ready, 1'b1);
    cfg_valid = 1'b1; cfg_period = W'(per); cfg_duty = W'(duty);
    cyc();
    cfg_valid = 1'b0;
    chk("cfg_ready_after", cfg_ready, 1'b0);
    if (idle) begin
      cyc();
      chk("cfg_ready_idle_apply", cfg_ready, 1'b1);
      m_per = (per == 0) ? 1 : per; m_duty = duty;
    end else begin
      m_pp = (per == 0) ? 1 : per; m_pd = duty; m_pend = 1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst is held
    cyc();
    chk("rst_pwm", pwm_out, 1'b0);
    chk("rst_done", period_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    rst = 1'b0;
    cyc();

    // Basic period=4 duty=1
    send_cfg(4, 1, 1);
    en = 1'b1;
    cyc();
    chk("start_busy", busy, 1'b1);
    chk("start_pwm", pwm_out, 1'b1);
    m_cnt = 0; m_pend = 0;
    for (int i = 0; i < 8; i++) model_tick("basic");

    // duty=0 -> constant low after the boundary
    send_cfg(4, 0, 0);
    for (int i = 0; i < 8; i++) model_tick("duty0");

    // duty > period -> constant high
    send_cfg(4, 5, 0);
    for (int i = 0; i < 8; i++) model_tick("duty_gt");

    // period=0 behaves as period 1
    send_cfg(0, 1, 0);
    for (int i = 0; i < 6; i++) model_tick("per0");

    // Shadow update mid-period, second offer blocked
    send_cfg(4, 2, 0);
    for (int i = 0; i < 3; i++) model_tick("shadow_a");
    send_cfg(8, 6, 0);
    cfg_valid = 1'b1; cfg_period = W'(3); cfg_duty = W'(3);
    #1;
    chk("cfg_blocked", cfg_ready, 1'b0);
    cyc();
    cfg_valid = 1'b0;
    for (int i = 0; i < 12; i++) model_tick("shadow_b");

    // Stop: drop en at cnt=1 of period 4
    send_cfg(4, 2, 0);
    for (int i = 0; i < 20 && !(m_per == 4 && m_cnt == 1 && !m_pend); i++) model_tick("align");
    en = 1'b0;
    cyc();
    chk("stop_busy", busy, 1'b1);
    model_tick("stop_c2");
    model_tick("stop_c3");
    tick_expect(1'b0, 1'b1, "stop_wrap");
    chk("stop_idle_busy", busy, 1'b0);
    tick_expect(1'b0, 1'b0, "idle_tick");
    m_cnt = 0;

    // Re-raising en during STOP continues seamlessly
    en = 1'b1;
    cyc();
    chk("restart_pwm", pwm_out, 1'b1);
    model_tick("rerun_a");
    en = 1'b0;
    cyc();
    model_tick("rerun_b");
    en = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) model_tick("rerun_c");
    chk("rerun_busy", busy, 1'b1);

    // Reset mid-run with a pending config
    send_cfg(8, 3, 0);
    rst = 1'b1;
    en = 1'b0;
    #1;
    chk("mrst_pwm", pwm_out, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", period_done, 1'b0);
    chk("mrst_ready", cfg_ready, 1'b1);
    cyc();
    rst = 1'b0;
    tick_expect(1'b0, 1'b0, "post_rst_idle");
    tick_expect(1'b0, 1'b0, "post_rst_idle");
    en = 1'b1;
    cyc();
    chk("post_rst_pwm", pwm_out, 1'b0);
    m_per = 1; m_duty = 0; m_cnt = 0; m_pend = 0;
    for (int i = 0; i < 3; i++) model_tick("post_rst_run");

`ifdef PWM_GEN_ONESHOT_EN
    en = 1'b0;
    cyc();
    tick_expect(1'b0, 1'b1, "os_stop");
    oneshot = 1'b1;
    send_cfg(3, 2, 1);
    en = 1'b1;
    cyc();
    chk("os_busy", busy, 1'b1);
    chk("os_pwm", pwm_out, 1'b1);
    m_cnt = 0;
    model_tick("os_c1");
    model_tick("os_c2");
    tick_expect(1'b0, 1'b1, "os_wrap");
    chk("os_idle", busy, 1'b0);
    tick_expect(1'b0, 1'b0, "os_hold");
    chk("os_no_restart", busy, 1'b0);
    en = 1'b0;
    cyc();
    en = 1'b1;
    oneshot = 1'b0;
    cyc();
    chk("os_restart", busy, 1'b1);
`endif

    en = 1'b0;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
